// File: rtl/cu_pkg.sv
// Shared constants for the accumulator CPU control unit: opcodes, FSM states,
// ALU select codes and the packed control vector driven into the datapath.
package cu_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_LDAC = 8'h01;
    localparam logic [7:0] OP_STAC = 8'h02;
    localparam logic [7:0] OP_MVAC = 8'h03;
    localparam logic [7:0] OP_MOVR = 8'h04;
    localparam logic [7:0] OP_JUMP = 8'h05;
    localparam logic [7:0] OP_JMPZ = 8'h06;
    localparam logic [7:0] OP_JPNZ = 8'h07;
    localparam logic [7:0] OP_ADD  = 8'h08;
    localparam logic [7:0] OP_SUB  = 8'h09;
    localparam logic [7:0] OP_INAC = 8'h0A;
    localparam logic [7:0] OP_CLAC = 8'h0B;
    localparam logic [7:0] OP_AND  = 8'h0C;
    localparam logic [7:0] OP_OR   = 8'h0D;
    localparam logic [7:0] OP_XOR  = 8'h0E;
    localparam logic [7:0] OP_NOT  = 8'h0F;

    localparam logic [6:0] ALU_CLAC = 7'b0000000;
    localparam logic [6:0] ALU_PASS = 7'b0000100;
    localparam logic [6:0] ALU_ADD  = 7'b0000101;
    localparam logic [6:0] ALU_INAC = 7'b0000110;
    localparam logic [6:0] ALU_SUB  = 7'b0001011;
    localparam logic [6:0] ALU_AND  = 7'b0010000;
    localparam logic [6:0] ALU_OR   = 7'b0100000;
    localparam logic [6:0] ALU_XOR  = 7'b0110000;
    localparam logic [6:0] ALU_NOT  = 7'b1000000;

    // Operand-fetch states are split per instruction family so that IR is only
    // consulted in DEC; each ALU op has its own OP1 state to keep outputs Moore.
    typedef enum logic [4:0] {
        S_RST, S_F1, S_F2, S_F3, S_DEC,
        S_A1_L, S_A2_L, S_A3_L, S_L4, S_L5,
        S_A1_S, S_A2_S, S_A3_S, S_S4, S_S5,
        S_A1_J, S_A2_J, S_J3,
        S_N1, S_N2, S_MV1, S_MR1,
        S_OP_ADD, S_OP_SUB, S_OP_INAC, S_OP_CLAC,
        S_OP_AND, S_OP_OR, S_OP_XOR, S_OP_NOT
    } state_t;

    typedef struct packed {
        logic       ar_load;
        logic       ar_inc;
        logic       pc_bus;
        logic       pc_load;
        logic       pc_inc;
        logic       pc_reset;
        logic       dr_bus_h;
        logic       dr_bus_l;
        logic       dr_load;
        logic       tr_bus;
        logic       tr_load;
        logic       ir_load;
        logic       r_bus;
        logic       r_load;
        logic       ac_bus;
        logic       ac_load;
        logic [6:0] alus;
        logic       membus;
        logic       busmem;
        logic       we;
    } ctrl_t;

endpackage

// File: rtl/cu_decode.sv
// Combinational decode of the control-unit state into the datapath control vector.
module cu_decode
    import cu_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_RST: ctrl.pc_reset = 1'b1;
            S_F1, S_F3: begin
                ctrl.pc_bus  = 1'b1;
                ctrl.ar_load = 1'b1;
                ctrl.ir_load = (state == S_F3);
            end
            S_F2, S_A1_L, S_A1_S, S_A1_J: begin
                ctrl.membus  = 1'b1;
                ctrl.dr_load = 1'b1;
                ctrl.pc_inc  = 1'b1;
                ctrl.ar_inc  = 1'b1;
            end
            S_A2_L, S_A2_S, S_A2_J: begin
                ctrl.tr_load = 1'b1;
                ctrl.membus  = 1'b1;
                ctrl.dr_load = 1'b1;
                ctrl.pc_inc  = 1'b1;
            end
            S_A3_L, S_A3_S: begin
                ctrl.dr_bus_h = 1'b1;
                ctrl.tr_bus   = 1'b1;
                ctrl.ar_load  = 1'b1;
            end
            S_J3: begin
                ctrl.dr_bus_h = 1'b1;
                ctrl.tr_bus   = 1'b1;
                ctrl.pc_load  = 1'b1;
            end
            S_L4: begin
                ctrl.membus  = 1'b1;
                ctrl.dr_load = 1'b1;
            end
            S_L5: begin
                ctrl.dr_bus_l = 1'b1;
                ctrl.ac_load  = 1'b1;
                ctrl.alus     = ALU_PASS;
            end
            S_S4: begin
                ctrl.ac_bus  = 1'b1;
                ctrl.dr_load = 1'b1;
            end
            S_S5: begin
                ctrl.dr_bus_l = 1'b1;
                ctrl.busmem   = 1'b1;
                ctrl.we       = 1'b1;
            end
            S_N1, S_N2: ctrl.pc_inc = 1'b1;
            S_MV1: begin
                ctrl.ac_bus = 1'b1;
                ctrl.r_load = 1'b1;
            end
            S_MR1: begin
                ctrl.r_bus   = 1'b1;
                ctrl.ac_load = 1'b1;
                ctrl.alus    = ALU_PASS;
            end
            S_OP_ADD:  begin ctrl.r_bus = 1'b1; ctrl.ac_load = 1'b1; ctrl.alus = ALU_ADD; end
            S_OP_SUB:  begin ctrl.r_bus = 1'b1; ctrl.ac_load = 1'b1; ctrl.alus = ALU_SUB; end
            S_OP_AND:  begin ctrl.r_bus = 1'b1; ctrl.ac_load = 1'b1; ctrl.alus = ALU_AND; end
            S_OP_OR:   begin ctrl.r_bus = 1'b1; ctrl.ac_load = 1'b1; ctrl.alus = ALU_OR;  end
            S_OP_XOR:  begin ctrl.r_bus = 1'b1; ctrl.ac_load = 1'b1; ctrl.alus = ALU_XOR; end
            S_OP_INAC: begin ctrl.ac_load = 1'b1; ctrl.alus = ALU_INAC; end
            S_OP_CLAC: begin ctrl.ac_load = 1'b1; ctrl.alus = ALU_CLAC; end
            S_OP_NOT:  begin ctrl.ac_load = 1'b1; ctrl.alus = ALU_NOT;  end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control unit for the 8-bit accumulator CPU: state register,
// next-state sequencing, and fan-out of the decoded control vector to the datapath.
module control_unit
    import cu_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] IR_TOCU,
    input  logic       Z_TOCU,
    output logic       AR_LOAD,
    output logic       AR_INC,
    output logic       PC_BUS,
    output logic       PC_LOAD,
    output logic       PC_INC,
    output logic       PC_RESET,
    output logic       DR_BUS_H,
    output logic       DR_BUS_L,
    output logic       DR_LOAD,
    output logic       TR_BUS,
    output logic       TR_LOAD,
    output logic       IR_LOAD,
    output logic       R_BUS,
    output logic       R_LOAD,
    output logic       AC_BUS,
    output logic       AC_LOAD,
    output logic       ALUS7,
    output logic       ALUS6,
    output logic       ALUS5,
    output logic       ALUS4,
    output logic       ALUS3,
    output logic       ALUS2,
    output logic       ALUS1,
    output logic       MEMBUS,
    output logic       BUSMEM,
    output logic       WE
);

    state_t state, next_state;
    ctrl_t  ctrl;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_RST;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_RST:  next_state = S_F1;
            S_F1:   next_state = S_F2;
            S_F2:   next_state = S_F3;
            S_F3:   next_state = S_DEC;
            S_DEC: begin
                case (IR_TOCU)
                    OP_LDAC: next_state = S_A1_L;
                    OP_STAC: next_state = S_A1_S;
                    OP_MVAC: next_state = S_MV1;
                    OP_MOVR: next_state = S_MR1;
                    OP_JUMP: next_state = S_A1_J;
                    OP_JMPZ: next_state = Z_TOCU  ? S_A1_J : S_N1;
                    OP_JPNZ: next_state = !Z_TOCU ? S_A1_J : S_N1;
                    OP_ADD:  next_state = S_OP_ADD;
                    OP_SUB:  next_state = S_OP_SUB;
                    OP_INAC: next_state = S_OP_INAC;
                    OP_CLAC: next_state = S_OP_CLAC;
                    OP_AND:  next_state = S_OP_AND;
                    OP_OR:   next_state = S_OP_OR;
                    OP_XOR:  next_state = S_OP_XOR;
                    OP_NOT:  next_state = S_OP_NOT;
                    default: next_state = S_F1;
                endcase
            end
            S_A1_L: next_state = S_A2_L;
            S_A2_L: next_state = S_A3_L;
            S_A3_L: next_state = S_L4;
            S_L4:   next_state = S_L5;
            S_A1_S: next_state = S_A2_S;
            S_A2_S: next_state = S_A3_S;
            S_A3_S: next_state = S_S4;
            S_S4:   next_state = S_S5;
            S_A1_J: next_state = S_A2_J;
            S_A2_J: next_state = S_J3;
            S_N1:   next_state = S_N2;
            S_L5, S_S5, S_J3, S_N2, S_MV1, S_MR1,
            S_OP_ADD, S_OP_SUB, S_OP_INAC, S_OP_CLAC,
            S_OP_AND, S_OP_OR, S_OP_XOR, S_OP_NOT:
                    next_state = S_F1;
            default: next_state = S_RST;
        endcase
    end

    cu_decode u_decode (
        .state (state),
        .ctrl  (ctrl)
    );

    assign AR_LOAD  = ctrl.ar_load;
    assign AR_INC   = ctrl.ar_inc;
    assign PC_BUS   = ctrl.pc_bus;
    assign PC_LOAD  = ctrl.pc_load;
    assign PC_INC   = ctrl.pc_inc;
    assign PC_RESET = ctrl.pc_reset;
    assign DR_BUS_H = ctrl.dr_bus_h;
    assign DR_BUS_L = ctrl.dr_bus_l;
    assign DR_LOAD  = ctrl.dr_load;
    assign TR_BUS   = ctrl.tr_bus;
    assign TR_LOAD  = ctrl.tr_load;
    assign IR_LOAD  = ctrl.ir_load;
    assign R_BUS    = ctrl.r_bus;
    assign R_LOAD   = ctrl.r_load;
    assign AC_BUS   = ctrl.ac_bus;
    assign AC_LOAD  = ctrl.ac_load;
    assign ALUS7    = ctrl.alus[6];
    assign ALUS6    = ctrl.alus[5];
    assign ALUS5    = ctrl.alus[4];
    assign ALUS4    = ctrl.alus[3];
    assign ALUS3    = ctrl.alus[2];
    assign ALUS2    = ctrl.alus[1];
    assign ALUS1    = ctrl.alus[0];
    assign MEMBUS   = ctrl.membus;
    assign BUSMEM   = ctrl.busmem;
    assign WE       = ctrl.we;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed instruction table, reset corner cases, and
// random instruction streams checked cycle-by-cycle against a micro-op list model.
module tb_control_unit;

    logic       clk, rst_n, z;
    logic [7:0] ir;
    logic ar_load, ar_inc, pc_bus, pc_load, pc_inc, pc_reset;
    logic dr_bus_h, dr_bus_l, dr_load, tr_bus, tr_load, ir_load;
    logic r_bus, r_load, ac_bus, ac_load;
    logic alus7, alus6, alus5, alus4, alus3, alus2, alus1;
    logic membus, busmem, we;
    logic [25:0] cur;

    int checks = 0;
    int errors = 0;

    control_unit dut (
        .CLK(clk), .RST_N(rst_n), .IR_TOCU(ir), .Z_TOCU(z),
        .AR_LOAD(ar_load), .AR_INC(ar_inc), .PC_BUS(pc_bus), .PC_LOAD(pc_load),
        .PC_INC(pc_inc), .PC_RESET(pc_reset), .DR_BUS_H(dr_bus_h), .DR_BUS_L(dr_bus_l),
        .DR_LOAD(dr_load), .TR_BUS(tr_bus), .TR_LOAD(tr_load), .IR_LOAD(ir_load),
        .R_BUS(r_bus), .R_LOAD(r_load), .AC_BUS(ac_bus), .AC_LOAD(ac_load),
        .ALUS7(alus7), .ALUS6(alus6), .ALUS5(alus5), .ALUS4(alus4),
        .ALUS3(alus3), .ALUS2(alus2), .ALUS1(alus1),
        .MEMBUS(membus), .BUSMEM(busmem), .WE(we)
    );

    assign cur = {ar_load, ar_inc, pc_bus, pc_load, pc_inc, pc_reset,
                  dr_bus_h, dr_bus_l, dr_load, tr_bus, tr_load, ir_load,
                  r_bus, r_load, ac_bus, ac_load,
                  alus7, alus6, alus5, alus4, alus3, alus2, alus1,
                  membus, busmem, we};

    localparam logic [25:0] M_AR_LOAD = 26'd1 << 25;
    localparam logic [25:0] M_AR_INC  = 26'd1 << 24;
    localparam logic [25:0] M_PC_BUS  = 26'd1 << 23;
    localparam logic [25:0] M_PC_LOAD = 26'd1 << 22;
    localparam logic [25:0] M_PC_INC  = 26'd1 << 21;
    localparam logic [25:0] M_PC_RST  = 26'd1 << 20;
    localparam logic [25:0] M_DR_BH   = 26'd1 << 19;
    localparam logic [25:0] M_DR_BL   = 26'd1 << 18;
    localparam logic [25:0] M_DR_LOAD = 26'd1 << 17;
    localparam logic [25:0] M_TR_BUS  = 26'd1 << 16;
    localparam logic [25:0] M_TR_LOAD = 26'd1 << 15;
    localparam logic [25:0] M_IR_LOAD = 26'd1 << 14;
    localparam logic [25:0] M_R_BUS   = 26'd1 << 13;
    localparam logic [25:0] M_R_LOAD  = 26'd1 << 12;
    localparam logic [25:0] M_AC_BUS  = 26'd1 << 11;
    localparam logic [25:0] M_AC_LOAD = 26'd1 << 10;
    localparam logic [25:0] M_MEMBUS  = 26'd1 << 2;
    localparam logic [25:0] M_BUSMEM  = 26'd1 << 1;
    localparam logic [25:0] M_WE      = 26'd1 << 0;

    localparam logic [25:0] V_RST = M_PC_RST;
    localparam logic [25:0] V_F1  = M_PC_BUS | M_AR_LOAD;
    localparam logic [25:0] V_F2  = M_MEMBUS | M_DR_LOAD | M_PC_INC | M_AR_INC;
    localparam logic [25:0] V_F3  = M_IR_LOAD | M_PC_BUS | M_AR_LOAD;
    localparam logic [25:0] V_A1  = M_MEMBUS | M_DR_LOAD | M_PC_INC | M_AR_INC;
    localparam logic [25:0] V_A2  = M_TR_LOAD | M_MEMBUS | M_DR_LOAD | M_PC_INC;
    localparam logic [25:0] V_A3  = M_DR_BH | M_TR_BUS | M_AR_LOAD;
    localparam logic [25:0] V_J3  = M_DR_BH | M_TR_BUS | M_PC_LOAD;
    localparam logic [25:0] V_L4  = M_MEMBUS | M_DR_LOAD;
    localparam logic [25:0] V_S4  = M_AC_BUS | M_DR_LOAD;
    localparam logic [25:0] V_S5  = M_DR_BL | M_BUSMEM | M_WE;
    localparam logic [25:0] V_N   = M_PC_INC;
    localparam logic [25:0] V_MV1 = M_AC_BUS | M_R_LOAD;

    function automatic logic [25:0] alu(input logic [6:0] code);
        return {16'd0, code, 3'd0};
    endfunction

    function automatic logic [25:0] alu_vec(input logic [7:0] op);
        case (op)
            8'h08: return M_R_BUS | M_AC_LOAD | alu(7'b0000101);
            8'h09: return M_R_BUS | M_AC_LOAD | alu(7'b0001011);
            8'h0C: return M_R_BUS | M_AC_LOAD | alu(7'b0010000);
            8'h0D: return M_R_BUS | M_AC_LOAD | alu(7'b0100000);
            8'h0E: return M_R_BUS | M_AC_LOAD | alu(7'b0110000);
            8'h0A: return M_AC_LOAD | alu(7'b0000110);
            8'h0B: return M_AC_LOAD | alu(7'b0000000);
            default: return M_AC_LOAD | alu(7'b1000000);
        endcase
    endfunction

    // Reference model: the list of per-cycle output vectors of one instruction.
    logic [25:0] exp_q[$];

    task automatic model_instr(input logic [7:0] op, input logic zf);
        logic taken;
        exp_q = {V_F1, V_F2, V_F3, 26'd0};
        taken = (op == 8'h05) || (op == 8'h06 && zf) || (op == 8'h07 && !zf);
        if (op == 8'h01)
            exp_q = {exp_q, V_A1, V_A2, V_A3, V_L4, M_DR_BL | M_AC_LOAD | alu(7'b0000100)};
        else if (op == 8'h02)
            exp_q = {exp_q, V_A1, V_A2, V_A3, V_S4, V_S5};
        else if (op == 8'h03)
            exp_q.push_back(V_MV1);
        else if (op == 8'h04)
            exp_q.push_back(M_R_BUS | M_AC_LOAD | alu(7'b0000100));
        else if (taken)
            exp_q = {exp_q, V_A1, V_A2, V_J3};
        else if (op == 8'h06 || op == 8'h07)
            exp_q = {exp_q, V_N, V_N};
        else if (op >= 8'h08 && op <= 8'h0F)
            exp_q.push_back(alu_vec(op));
    endtask

    task automatic check(input string name, input logic [25:0] got, input logic [25:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0]  op;
        logic        zf;
        int          cycles;
        logic [25:0] last;
    } vec_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        vec_t tbl[$];
        int   cnt;
        logic [25:0] last;

        rst_n = 1'b0;
        ir    = 8'h00;
        z     = 1'b0;

        tbl = '{
            '{8'h00, 1'b0, 4, 26'd0},
            '{8'h01, 1'b0, 9, M_DR_BL | M_AC_LOAD | alu(7'b0000100)},
            '{8'h02, 1'b1, 9, V_S5},
            '{8'h03, 1'b0, 5, V_MV1},
            '{8'h04, 1'b0, 5, M_R_BUS | M_AC_LOAD | alu(7'b0000100)},
            '{8'h05, 1'b0, 7, V_J3},
            '{8'h06, 1'b1, 7, V_J3},
            '{8'h06, 1'b0, 6, V_N},
            '{8'h07, 1'b0, 7, V_J3},
            '{8'h07, 1'b1, 6, V_N},
            '{8'h08, 1'b0, 5, M_R_BUS | M_AC_LOAD | alu(7'b0000101)},
            '{8'h0B, 1'b0, 5, M_AC_LOAD},
            '{8'h0F, 1'b1, 5, M_AC_LOAD | alu(7'b1000000)},
            '{8'h3A, 1'b0, 4, 26'd0}
        };

        // Power-on reset and release
        #12;
        check("reset_hold", cur, V_RST);
        rst_n = 1'b1;
        #1;
        check("reset_release_rst", cur, V_RST);
        step();
        check("first_f1", cur, V_F1);

        // Directed table: cycles F1..F1 and the last execute-cycle vector
        foreach (tbl[i]) begin
            ir = tbl[i].op;
            z  = tbl[i].zf;
            cnt  = 0;
            last = cur;
            do begin
                last = cur;
                step();
                cnt++;
            end while (cur !== V_F1 && cnt < 20);
            check_int($sformatf("cycles_op%02h_z%0d", tbl[i].op, tbl[i].zf), cnt, tbl[i].cycles);
            check($sformatf("last_op%02h_z%0d", tbl[i].op, tbl[i].zf), last, tbl[i].last);
        end

        // STAC: WE only in one cycle
        ir = 8'h02;
        cnt = 0;
        for (int i = 0; i < 9; i++) begin
            if (cur[0]) cnt++;
            step();
        end
        check_int("stac_we_cycles", cnt, 1);
        check("stac_back_f1", cur, V_F1);

        // Reset asserted mid-LDAC at L4
        ir = 8'h01;
        for (int i = 0; i < 7; i++) step();
        check("ldac_at_l4", cur, V_L4);
        #2 rst_n = 1'b0;
        #1;
        check("reset_mid_ldac", cur, V_RST);
        #2 rst_n = 1'b1;
        #1;
        check("reset_mid_release", cur, V_RST);
        step();
        check("reset_mid_f1", cur, V_F1);

        // Random instruction stream against the model
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) < 7) ir = 8'($urandom_range(0, 15));
            else                          ir = 8'($urandom);
            z = 1'($urandom_range(0, 1));
            model_instr(ir, z);
            foreach (exp_q[k]) begin
                if (k != 0) step();
                check($sformatf("rand%0d_op%02h_z%0d_c%0d", n, ir, z, k), cur, exp_q[k]);
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
